fft_result_serializer: RTL and testbench
========================================

Name: fft_result_serializer

Overview:
- Snapshots one complete FFT result frame of NUM_POINTS complex words and streams it byte-by-byte to the UART transmitter.
- Uses a one-byte-in-flight start/done handshake.
- Generalised successor to the fixed 16-point, real-only, 32-byte result path: parametrised point count and word width, optional imaginary channel, sync header, and overrun detection.
- Sits between the FFT core's done strobe and UART_TX.

Parameters:
NUM_POINTS, 16, number of FFT bins per frame (≥2)
WORD_SIZE, 16, bits per real/imag word; multiple of 8, ≥8
SYNC_BYTE, 8'hA5, header byte sent before each frame

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_frame_valid  in  1  one-cycle strobe: i_frame_re/i_frame_im hold a complete result
i_frame_re  in  NUM_POINTS*WORD_SIZE  flattened real parts, bin k at [k*WORD_SIZE +: WORD_SIZE]
i_frame_im  in  NUM_POINTS*WORD_SIZE  flattened imag parts, same packing
i_mode_im  in  1  sampled with i_frame_valid: 0 = real only, 1 = real and imag per bin
o_tx_start  out  1  one-cycle pulse to UART_TX: send o_tx_byte
o_tx_byte  out  8  byte to transmit, stable from o_tx_start until i_tx_done
i_tx_done  in  1  one-cycle pulse from UART_TX: byte finished
o_busy  out  1  frame transmission in progress
o_frame_done  out  1  one-cycle pulse after the last byte's i_tx_done
o_overrun  out  1  one-cycle pulse: i_frame_valid arrived while busy

Behaviour:
- Reset (i_rst=0, asynchronous):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Byte counter is 0.
  - Snapshot registers are 0.
- Derived quantities:
  - BPW = WORD_SIZE/8.
  - Data bytes D = NUM_POINTS*BPW*(1+mode).
  - Frame length = 1 (header) + D (+1 with checksum).
- Byte order:
  - SYNC_BYTE first.
  - Then bins 0..NUM_POINTS-1 in ascending order.
  - Per bin: real word bytes LSB-first; then, if mode=1, imag word bytes LSB-first.
- FSM states:
  - IDLE: on i_frame_valid, latch both buses and i_mode_im, then go to SEND. o_busy=1 from the next cycle.
  - SEND: drive o_tx_byte for the current index and assert o_tx_start for exactly one cycle, then go to WAIT.
  - WAIT: hold o_tx_byte. On i_tx_done, either increment the index and go to SEND, or, if this was the last byte, go to DONE.
  - DONE: pulse o_frame_done for one cycle with o_busy=0 in the same cycle, then go to IDLE.
- Latency:
  - i_frame_valid in cycle n → o_tx_start=1 and o_tx_byte=SYNC_BYTE in cycle n+1.
  - i_tx_done in cycle m → next o_tx_start in cycle m+1.
  - A new i_frame_valid is accepted from the o_frame_done cycle onward. It is treated as in IDLE: a valid in the DONE cycle starts a new frame with a start pulse 1 cycle later.
- Byte selection uses an index counter into the latched snapshot. The counter is wide enough for the maximum frame length (mode=1 plus checksum). There is no wrap: the frame ends at the last index and the counter clears in DONE.
- Boundary conditions:
  - i_frame_valid while busy (SEND/WAIT): ignored, snapshot untouched, o_overrun pulses in the next cycle.
  - i_tx_done outside WAIT: ignored.
  - i_tx_done coinciding with o_tx_start: ignored, because the FSM is still in SEND.
  - i_mode_im changes mid-frame: no effect.
  - Reset mid-frame: transmission aborts immediately, no further o_tx_start, no o_frame_done. The next frame restarts with SYNC_BYTE.
- o_tx_start never rises twice without an intervening accepted i_tx_done.

Optional Feature:
- Macro: FFT_SER_CHECKSUM_EN.
- Defined: after the last data byte, one extra byte is sent. It is the XOR of all data bytes, excluding SYNC_BYTE. The running XOR is cleared at frame start and updated on each accepted i_tx_done of a data byte.
- Undefined: no checksum byte, no XOR logic, and o_frame_done follows the last data byte.

Test Plan:
1. Hold i_rst=0 with random inputs, then release → all outputs 0, no o_tx_start for 20 cycles; a spurious i_tx_done in IDLE → no response.
2. Defaults, mode 0, re[k]=16'h0100+k, responder returns i_tx_done 5 cycles after each start → bytes A5,00,01,01,01,02,01…0F,01 (33 starts); o_frame_done once; o_busy falls in the same cycle.
3. Mode 1, re[k]=k, im[k]=16'hFF00|k → A5, then per bin k,00,k,FF; 65 bytes total; first start exactly 1 cycle after i_frame_valid.
4. Second i_frame_valid during byte 10 with different data → one o_overrun pulse, remaining bytes still from the first snapshot, a single o_frame_done.
5. i_rst low for 1 cycle after the 5th i_tx_done → o_busy/o_tx_start drop immediately, no o_frame_done; a new frame begins with A5.
6. FFT_SER_CHECKSUM_EN, mode 0, re[0]=16'h00FF, rest 0 → 34 bytes, last byte 8'hFF; re[0]=re[1]=16'h00FF → last byte 8'h00.

Source files
------------

// File: rtl/fft_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fft_result_serializer
// Purpose  : Snapshots one FFT result frame (NUM_POINTS complex words) and
//            streams it byte-by-byte to a UART transmitter with a
//            one-byte-in-flight start/done handshake.
//            Frame layout: SYNC_BYTE, then per bin the real word LSB-first,
//            followed by the imaginary word LSB-first when mode_im=1,
//            optionally followed by an XOR checksum byte.
// Ports    : i_clk, i_rst (async, active-low)
//            i_frame_valid, i_frame_re, i_frame_im, i_mode_im : frame input
//            o_tx_start, o_tx_byte, i_tx_done                 : UART_TX side
//            o_busy, o_frame_done, o_overrun                  : status
// Options  : FFT_SER_CHECKSUM_EN - append XOR of all data bytes to each frame
// Revision : 1.0 - initial release
// ============================================================================
module fft_result_serializer #(
  parameter int         NUM_POINTS = 16,
  parameter int         WORD_SIZE  = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_frame_valid,
  input  logic [NUM_POINTS*WORD_SIZE-1:0] i_frame_re,
  input  logic [NUM_POINTS*WORD_SIZE-1:0] i_frame_im,
  input  logic                           i_mode_im,
  output logic                           o_tx_start,
  output logic [7:0]                     o_tx_byte,
  input  logic                           i_tx_done,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic                           o_overrun
);

  localparam int BPW     = WORD_SIZE / 8;
  localparam int D_REAL  = NUM_POINTS * BPW;
  localparam int D_CPLX  = 2 * D_REAL;
`ifdef FFT_SER_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif
  localparam int MAX_LEN = 1 + D_CPLX + CSUM_BYTES;
  localparam int IDX_W   = $clog2(MAX_LEN);
  // Index 0 is the header, so the last index equals the data+checksum count.
  localparam logic [IDX_W-1:0] LAST_REAL = IDX_W'(D_REAL + CSUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_CPLX = IDX_W'(D_CPLX + CSUM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                           state;
  state_t                           next_state;
  logic [IDX_W-1:0]                 idx;
  logic [IDX_W-1:0]                 last_idx;
  logic [IDX_W-1:0]                 data_idx;
  logic [NUM_POINTS*WORD_SIZE-1:0]  snap_re;
  logic [NUM_POINTS*WORD_SIZE-1:0]  snap_im;
  logic                             snap_mode;
  logic [2*NUM_POINTS*WORD_SIZE-1:0] interleaved;
  logic [2*NUM_POINTS*WORD_SIZE-1:0] data_flat;
  logic [7:0]                       data_byte;
  logic [7:0]                       cur_byte;
  logic                             active;
  logic                             accept;
  logic                             overrun_pulse;
  logic                             byte_acked;

  assign active     = (state == SEND) || (state == WAIT);
  // DONE behaves like IDLE for new frames so back-to-back frames lose no cycle.
  assign accept     = i_frame_valid && ((state == IDLE) || (state == DONE));
  assign last_idx   = snap_mode ? LAST_CPLX : LAST_REAL;
  assign data_idx   = idx - IDX_W'(1);
  assign byte_acked = (state == WAIT) && i_tx_done;

  // Complex mode: lay out {im[k], re[k]} per bin so the byte stream becomes a
  // plain LSB-first walk through one flat vector.
  genvar k;
  generate
    for (k = 0; k < NUM_POINTS; k++) begin : g_interleave
      assign interleaved[k*2*WORD_SIZE +: WORD_SIZE]             = snap_re[k*WORD_SIZE +: WORD_SIZE];
      assign interleaved[k*2*WORD_SIZE + WORD_SIZE +: WORD_SIZE] = snap_im[k*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  assign data_flat = snap_mode ? interleaved
                               : {{(NUM_POINTS*WORD_SIZE){1'b0}}, snap_re};
  // Byte offset as {idx, 3'b000} avoids overflow of a narrow multiply.
  assign data_byte = data_flat[{data_idx, 3'b000} +: 8];

`ifdef FFT_SER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      csum <= 8'h00;
    end else if (accept) begin
      csum <= 8'h00;
    end else if (byte_acked && (idx != '0) && (idx != last_idx)) begin
      csum <= csum ^ data_byte;
    end
  end

  always_comb begin
    cur_byte = data_byte;
    if (idx == '0) begin
      cur_byte = SYNC_BYTE;
    end else if (idx == last_idx) begin
      cur_byte = csum;
    end
  end
`else
  always_comb begin
    cur_byte = data_byte;
    if (idx == '0) begin
      cur_byte = SYNC_BYTE;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    o_tx_start   = 1'b0;
    o_busy       = active;
    o_frame_done = 1'b0;
    o_tx_byte    = active ? cur_byte : 8'h00;
    o_overrun    = overrun_pulse;
    case (state)
      IDLE: begin
        if (i_frame_valid) next_state = SEND;
      end
      SEND: begin
        o_tx_start = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (i_tx_done) next_state = (idx == last_idx) ? DONE : SEND;
      end
      DONE: begin
        o_frame_done = 1'b1;
        next_state   = i_frame_valid ? SEND : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      idx           <= '0;
      snap_re       <= '0;
      snap_im       <= '0;
      snap_mode     <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      overrun_pulse <= i_frame_valid && active;
      if (accept) begin
        snap_re   <= i_frame_re;
        snap_im   <= i_frame_im;
        snap_mode <= i_mode_im;
        idx       <= '0;
      end else if (state == DONE) begin
        idx <= '0;
      end else if (byte_acked && (idx != last_idx)) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_result_serializer
// Purpose  : Self-checking bench for fft_result_serializer. Expected bytes are
//            queued when a frame is driven and compared as each o_tx_start
//            appears; a responder returns i_tx_done a fixed delay later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_result_serializer;

  localparam int         N    = 16;
  localparam int         W    = 16;
  localparam int         BPW  = W / 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         RESP_DLY = 5;
`ifdef FFT_SER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic           clk = 1'b0;
  logic           i_rst;
  logic           i_frame_valid;
  logic [N*W-1:0] i_frame_re;
  logic [N*W-1:0] i_frame_im;
  logic           i_mode_im;
  logic           o_tx_start;
  logic [7:0]     o_tx_byte;
  logic           i_tx_done;
  logic           o_busy;
  logic           o_frame_done;
  logic           o_overrun;

  fft_result_serializer #(.NUM_POINTS(N), .WORD_SIZE(W), .SYNC_BYTE(SYNC)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_frame_valid(i_frame_valid),
    .i_frame_re   (i_frame_re),
    .i_frame_im   (i_frame_im),
    .i_mode_im    (i_mode_im),
    .o_tx_start   (o_tx_start),
    .o_tx_byte    (o_tx_byte),
    .i_tx_done    (i_tx_done),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         starts = 0;
  int         frame_dones = 0;
  int         overruns = 0;
  int         resp_dones = 0;
  int         countdown = 0;
  bit         outstanding = 0;
  bit         rand_done = 0;
  int         spur_cnt = 0;
  int         spur_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference byte stream for one frame.
  task automatic push_frame(input logic [N*W-1:0] re, input logic [N*W-1:0] im, input logic mode);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(SYNC);
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < BPW; j++) begin
        b = re[k*W + j*8 +: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
      if (mode) begin
        for (int j = 0; j < BPW; j++) begin
          b = im[k*W + j*8 +: 8];
          exp_q.push_back(b);
          x = x ^ b;
        end
      end
    end
    if (EXTRA == 1) exp_q.push_back(x);
  endtask

  task automatic scramble_buses();
    for (int k = 0; k < N; k++) begin
      i_frame_re[k*W +: W] = W'($urandom);
      i_frame_im[k*W +: W] = W'($urandom);
    end
  endtask

  task automatic drive_valid(input logic [N*W-1:0] re, input logic [N*W-1:0] im, input logic mode,
                             input bit push);
    @(negedge clk);
    i_frame_re    = re;
    i_frame_im    = im;
    i_mode_im     = mode;
    i_frame_valid = 1'b1;
    if (push) push_frame(re, im, mode);
    @(negedge clk);
    i_frame_valid = 1'b0;
    i_mode_im     = ~mode;
    scramble_buses();
  endtask

  task automatic send_frame(input logic [N*W-1:0] re, input logic [N*W-1:0] im, input logic mode);
    drive_valid(re, im, mode, 1'b1);
    check_val("lat_start", 32'(o_tx_start), 32'd1);
    check_val("lat_sync", 32'(o_tx_byte), 32'(SYNC));
  endtask

  task automatic wait_frame(input int base);
    int n;
    n = 0;
    while (frame_dones == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("frame_timeout", 32'(frame_dones == base), 32'd0);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor and UART responder, all at the falling edge.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        countdown   = 0;
        outstanding = 0;
        exp_q.delete();
        i_tx_done = rand_done ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        i_tx_done = 1'b0;
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            i_tx_done   = 1'b1;
            outstanding = 0;
            resp_dones++;
          end
        end
        if (spur_cnt != spur_seen) begin
          spur_seen = spur_cnt;
          i_tx_done = 1'b1;
        end
        if (o_tx_start) begin
          starts++;
          if (outstanding) check_val("double_start", 32'd1, 32'd0);
          outstanding = 1;
          countdown   = RESP_DLY;
          if (exp_q.size() == 0) begin
            check_val("unexpected_start", 32'(o_tx_byte), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_val("tx_byte", 32'(o_tx_byte), 32'(e));
          end
        end
        if (o_frame_done) begin
          frame_dones++;
          check_val("busy_at_done", 32'(o_busy), 32'd0);
        end
        if (o_overrun) overruns++;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N*W-1:0] re;
    logic [N*W-1:0] im;
    int             s0;
    int             f0;
    int             o0;
    int             r0;
    int             n;

    i_rst         = 1'b0;
    i_frame_valid = 1'b0;
    i_mode_im     = 1'b0;
    i_frame_re    = '0;
    i_frame_im    = '0;
    rand_done     = 1;

    // 1: reset with random inputs, then idle quiet.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      i_frame_valid = 1'($urandom_range(0, 1));
      i_mode_im     = 1'($urandom_range(0, 1));
      scramble_buses();
      if (c >= 5)
        check_val("reset_outputs", 32'({o_tx_start, o_tx_byte, o_busy, o_frame_done, o_overrun}), 32'd0);
    end
    @(negedge clk);
    i_frame_valid = 1'b0;
    rand_done     = 0;
    @(posedge clk);
    #2 i_rst = 1'b1;
    repeat (20) @(negedge clk);
    check_val("idle_no_start", 32'(starts), 32'd0);
    spur_cnt++;
    repeat (6) @(negedge clk);
    check_val("spurious_done_start", 32'(starts), 32'd0);
    check_val("spurious_done_busy", 32'(o_busy), 32'd0);

    // 2: real-only frame, re[k] = 0x0100 + k.
    for (int k = 0; k < N; k++) begin
      re[k*W +: W] = 16'h0100 + 16'(k);
      im[k*W +: W] = 16'h5A5A;
    end
    s0 = starts; f0 = frame_dones;
    send_frame(re, im, 1'b0);
    @(negedge clk);
    check_val("busy_during", 32'(o_busy), 32'd1);
    wait_frame(f0);
    repeat (3) @(negedge clk);
    check_val("m0_starts", 32'(starts - s0), 32'(33 + EXTRA));
    check_val("m0_frame_done_once", 32'(frame_dones - f0), 32'd1);

    // 3: complex frame, re[k] = k, im[k] = 0xFF00 | k.
    for (int k = 0; k < N; k++) begin
      re[k*W +: W] = 16'(k);
      im[k*W +: W] = 16'hFF00 | 16'(k);
    end
    s0 = starts; f0 = frame_dones;
    send_frame(re, im, 1'b1);
    wait_frame(f0);
    repeat (3) @(negedge clk);
    check_val("m1_starts", 32'(starts - s0), 32'(65 + EXTRA));

    // 4: second valid while busy -> overrun, first snapshot kept.
    for (int k = 0; k < N; k++) begin
      re[k*W +: W] = 16'h3000 + 16'(k * 7);
      im[k*W +: W] = 16'h0;
    end
    s0 = starts; f0 = frame_dones; o0 = overruns;
    send_frame(re, im, 1'b0);
    n = 0;
    while (starts - s0 < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("ovr_reach_byte10", 32'(starts - s0 >= 10), 32'd1);
    drive_valid(~re, ~re, 1'b1, 1'b0);
    @(negedge clk);
    wait_frame(f0);
    repeat (20) @(negedge clk);
    check_val("ovr_pulses", 32'(overruns - o0), 32'd1);
    check_val("ovr_frame_done", 32'(frame_dones - f0), 32'd1);
    check_val("ovr_starts", 32'(starts - s0), 32'(33 + EXTRA));

    // 5: reset after the 5th i_tx_done aborts the frame.
    s0 = starts; f0 = frame_dones; r0 = resp_dones;
    send_frame(re, im, 1'b0);
    n = 0;
    while (resp_dones - r0 < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_reach_done5", 32'(resp_dones - r0), 32'd5);
    @(posedge clk);
    #2 i_rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_start", 32'(o_tx_start), 32'd0);
    @(posedge clk);
    #2 i_rst = 1'b1;
    s0 = starts;
    repeat (20) @(negedge clk);
    check_val("rst_no_frame_done", 32'(frame_dones - f0), 32'd0);
    check_val("rst_no_start", 32'(starts - s0), 32'd0);
    for (int k = 0; k < N; k++) re[k*W +: W] = 16'(16'hC0DE ^ 16'(k));
    f0 = frame_dones;
    send_frame(re, im, 1'b0);
    wait_frame(f0);

    // 6: checksum patterns (checksum byte present only when enabled).
    re = '0;
    re[0 +: W] = 16'h00FF;
    s0 = starts; f0 = frame_dones;
    send_frame(re, im, 1'b0);
    wait_frame(f0);
    repeat (3) @(negedge clk);
    check_val("cs1_starts", 32'(starts - s0), 32'(33 + EXTRA));
    re[W +: W] = 16'h00FF;
    s0 = starts; f0 = frame_dones;
    send_frame(re, im, 1'b0);
    wait_frame(f0);
    repeat (3) @(negedge clk);
    check_val("cs2_starts", 32'(starts - s0), 32'(33 + EXTRA));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
